// File: rtl/threshold_mean_calc_pkg.sv
// Shared types and defaults for the frame-mean threshold generator.
package threshold_mean_calc_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCUM  = 2'd1,
    DIVIDE = 2'd2
  } state_t;

  localparam int PIXEL_W_DEF        = 8;
  localparam int DEFAULT_THRESH_DEF = 128;

endpackage

// File: rtl/threshold_mean_calc_if.sv
// Pixel stream in, threshold/ready/done out. The master side drives the
// pixel stream; the slave side is the threshold generator.
interface threshold_mean_calc_if
  import threshold_mean_calc_pkg::*;
#(
  parameter int PIXEL_W = PIXEL_W_DEF
);
  logic               start;
  logic [PIXEL_W-1:0] pixel_in;
  logic               pixel_valid;
  logic [PIXEL_W-1:0] threshold;
  logic               ready;
  logic               done;

  modport master (
    output start, pixel_in, pixel_valid,
    input  threshold, ready, done
  );

  modport slave (
    input  start, pixel_in, pixel_valid,
    output threshold, ready, done
  );
endinterface

// File: rtl/threshold_mean_calc_seq_divider.sv
// Restoring divider: one quotient bit per clock, MSB first. The quotient
// register doubles as the dividend shift register. valid pulses for one
// cycle once all W bits have been produced.
module seq_divider #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] dividend,
  input  logic [W-1:0] divisor,
  output logic [W-1:0] quotient,
  output logic         valid
);
  localparam int CW = $clog2(W + 1);

  logic [W-1:0]  rem_q, rem_d;
  logic [W-1:0]  quo_q, quo_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          valid_q, valid_d;
  logic [W:0]    shifted;
  logic          ge;

  // Next-state: load operands, or retire one quotient bit while cnt is nonzero.
  always_comb begin
    rem_d   = rem_q;
    quo_d   = quo_q;
    cnt_d   = cnt_q;
    valid_d = 1'b0;
    shifted = {rem_q, quo_q[W-1]};
    ge      = (shifted >= {1'b0, divisor});
    if (load) begin
      rem_d = '0;
      quo_d = dividend;
      cnt_d = CW'(W);
    end else if (cnt_q != '0) begin
      // Remainder stays below the divisor, so the difference fits in W bits.
      rem_d   = ge ? (shifted[W-1:0] - divisor) : shifted[W-1:0];
      quo_d   = {quo_q[W-2:0], ge};
      cnt_d   = cnt_q - CW'(1);
      valid_d = (cnt_q == CW'(1));
    end
  end

  // Divider state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rem_q   <= '0;
      quo_q   <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
    end
  end

  assign quotient = quo_q;
  assign valid    = valid_q;
endmodule

// File: rtl/threshold_mean_calc.sv
// Frame-mean threshold generator: accumulates NUM_PIXELS pixels after a
// start request, divides the sum by NUM_PIXELS and publishes the truncated
// mean as the new threshold. ready is high while a new value is in flight.
module threshold_mean_calc
  import threshold_mean_calc_pkg::*;
#(
  parameter int PIXEL_W        = PIXEL_W_DEF,
  parameter int NUM_PIXELS     = 16384,
  parameter int DEFAULT_THRESH = DEFAULT_THRESH_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  threshold_mean_calc_if.slave   bus
);
  localparam int SUM_W = PIXEL_W + $clog2(NUM_PIXELS + 1);
  localparam int CNT_W = $clog2(NUM_PIXELS + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_PIXELS - 1);

  state_t               state_q, state_d;
  logic [SUM_W-1:0]     sum_q, sum_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic [PIXEL_W-1:0]   thr_q, thr_d;
  logic                 ready_q, ready_d;
  logic                 done_q, done_d;

  logic [SUM_W-1:0]     sum_next;
  logic                 div_load;
  logic [SUM_W-1:0]     div_quo;
  logic                 div_valid;
  logic [SUM_W-PIXEL_W-1:0] unused_quo_hi;

  // The last pixel's sum goes straight into the divider on the same edge
  // that accepts it, so the result lands SUM_W+1 edges later.
  assign sum_next = sum_q + SUM_W'(bus.pixel_in);

  seq_divider #(.W(SUM_W)) u_div (
    .clk      (clk),
    .rst      (rst),
    .load     (div_load),
    .dividend (sum_next),
    .divisor  (SUM_W'(NUM_PIXELS)),
    .quotient (div_quo),
    .valid    (div_valid)
  );

  // Mean never exceeds the max pixel value; the upper quotient bits are zero.
  assign unused_quo_hi = div_quo[SUM_W-1:PIXEL_W];

  // FSM next-state plus accumulator, counter and output register updates.
  always_comb begin
    state_d  = state_q;
    sum_d    = sum_q;
    count_d  = count_q;
    thr_d    = thr_q;
    ready_d  = ready_q;
    done_d   = 1'b0;
    div_load = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = ACCUM;
          sum_d   = '0;
          count_d = '0;
          ready_d = 1'b1;
        end
      end
      ACCUM: begin
        if (bus.pixel_valid) begin
          sum_d   = sum_next;
          count_d = count_q + CNT_W'(1);
          if (count_q == LAST_CNT) begin
            state_d  = DIVIDE;
            div_load = 1'b1;
          end
        end
      end
      DIVIDE: begin
        if (div_valid) begin
          thr_d   = div_quo[PIXEL_W-1:0];
          done_d  = 1'b1;
          ready_d = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset aborts any frame in progress.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      sum_q   <= '0;
      count_q <= '0;
      thr_q   <= PIXEL_W'(DEFAULT_THRESH);
      ready_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sum_q   <= sum_d;
      count_q <= count_d;
      thr_q   <= thr_d;
      ready_q <= ready_d;
      done_q  <= done_d;
    end
  end

  assign bus.threshold = thr_q;
  assign bus.ready     = ready_q;
  assign bus.done      = done_q;
endmodule

// File: tb/tb_threshold_mean_calc.sv
// Bench: two instances (4-pixel and 1-pixel frames) driven with directed and
// random frames; expected thresholds are plain integer means of the pixels.
module tb_threshold_mean_calc;
  localparam int NPA = 4;
  localparam int NPB = 1;
  localparam int SWA = 8 + $clog2(NPA + 1);
  localparam int SWB = 8 + $clog2(NPB + 1);

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  threshold_mean_calc_if #(.PIXEL_W(8)) if_a ();
  threshold_mean_calc_if #(.PIXEL_W(8)) if_b ();

  threshold_mean_calc #(.PIXEL_W(8), .NUM_PIXELS(NPA), .DEFAULT_THRESH(128)) dut_a (
    .clk (clk), .rst (rst), .bus (if_a)
  );
  threshold_mean_calc #(.PIXEL_W(8), .NUM_PIXELS(NPB), .DEFAULT_THRESH(128)) dut_b (
    .clk (clk), .rst (rst), .bus (if_b)
  );

  int total = 0;
  int bad   = 0;
  logic [7:0] thr_a = 8'd128;
  logic [7:0] thr_b = 8'd128;
  logic [7:0] fpx [NPA];
  int         fgap[NPA];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // One frame on instance A using fpx/fgap. noise: extra start pulses in
  // ACCUM and DIVIDE plus a stray pixel in DIVIDE. pre: start already
  // accepted by the previous frame. chain: raise start in the done cycle.
  task automatic frame_a(input bit noise, input bit pre, input bit chain);
    int s;
    logic [7:0] expv;
    s = 0;
    for (int i = 0; i < NPA; i++) s += int'(fpx[i]);
    expv = 8'(s / NPA);
    if (!pre) begin
      @(negedge clk); if_a.start = 1'b1;
      @(negedge clk); if_a.start = 1'b0;
      chk("a_start_ready", 32'(if_a.ready), 32'd1);
    end
    for (int i = 0; i < NPA; i++) begin
      for (int g = 0; g < fgap[i]; g++) begin
        @(negedge clk);
        if_a.pixel_valid = 1'b0;
        if_a.pixel_in    = 8'($urandom);
        if_a.start       = noise && (g == 0);
        chk("a_accum_busy", 32'({if_a.ready, if_a.done}), 32'd2);
      end
      @(negedge clk);
      if_a.start       = 1'b0;
      if_a.pixel_valid = 1'b1;
      if_a.pixel_in    = fpx[i];
    end
    @(negedge clk);
    if_a.pixel_valid = noise;
    if_a.pixel_in    = 8'd200;
    if_a.start       = noise;
    chk("a_last_busy", 32'({if_a.ready, if_a.done}), 32'd2);
    for (int k = 1; k <= SWA + 1; k++) begin
      @(negedge clk);
      if_a.pixel_valid = 1'b0;
      if_a.start       = 1'b0;
      if (k <= SWA) begin
        chk("a_div_busy", 32'({if_a.ready, if_a.done, if_a.threshold}), 32'({2'b10, thr_a}));
      end else begin
        chk("a_done", 32'({if_a.ready, if_a.done, if_a.threshold}), 32'({2'b01, expv}));
        thr_a = expv;
        if (chain) if_a.start = 1'b1;
      end
    end
    @(negedge clk);
    if_a.start = 1'b0;
    chk("a_done_drop", 32'({if_a.ready, if_a.done, if_a.threshold}), 32'({chain, 1'b0, thr_a}));
  endtask

  // One frame on instance B (single-pixel frames). A pixel offered in the
  // start cycle must be ignored.
  task automatic frame_b(input logic [7:0] px);
    @(negedge clk);
    if_b.start       = 1'b1;
    if_b.pixel_valid = 1'b1;
    if_b.pixel_in    = ~px;
    @(negedge clk);
    if_b.start    = 1'b0;
    if_b.pixel_in = px;
    chk("b_start_ready", 32'({if_b.ready, if_b.done}), 32'd2);
    @(negedge clk);
    if_b.pixel_valid = 1'b0;
    for (int k = 1; k <= SWB + 1; k++) begin
      @(negedge clk);
      if (k <= SWB) begin
        chk("b_div_busy", 32'({if_b.ready, if_b.done, if_b.threshold}), 32'({2'b10, thr_b}));
      end else begin
        chk("b_done", 32'({if_b.ready, if_b.done, if_b.threshold}), 32'({2'b01, px}));
        thr_b = px;
      end
    end
    @(negedge clk);
    chk("b_done_drop", 32'({if_b.ready, if_b.done, if_b.threshold}), 32'({2'b00, thr_b}));
  endtask

  task automatic set_frame(input logic [7:0] p0, p1, p2, p3, input int gap);
    fpx[0] = p0; fpx[1] = p1; fpx[2] = p2; fpx[3] = p3;
    for (int i = 0; i < NPA; i++) fgap[i] = gap;
  endtask

  initial begin
    bit prev_chain;
    bit ch;
    if_a.start = 1'b0; if_a.pixel_valid = 1'b0; if_a.pixel_in = '0;
    if_b.start = 1'b0; if_b.pixel_valid = 1'b0; if_b.pixel_in = '0;
    repeat (3) @(negedge clk);
    chk("rst_a", 32'({if_a.ready, if_a.done, if_a.threshold}), 32'({2'b00, 8'd128}));
    chk("rst_b", 32'({if_b.ready, if_b.done, if_b.threshold}), 32'({2'b00, 8'd128}));
    rst = 1'b0;

    // Idle with valid pixels: nothing may change.
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if_a.pixel_valid = 1'b1; if_a.pixel_in = 8'($urandom);
      if_b.pixel_valid = 1'b1; if_b.pixel_in = 8'($urandom);
      chk("idle_a", 32'({if_a.ready, if_a.done, if_a.threshold}), 32'({2'b00, 8'd128}));
      chk("idle_b", 32'({if_b.ready, if_b.done, if_b.threshold}), 32'({2'b00, 8'd128}));
    end
    @(negedge clk);
    if_a.pixel_valid = 1'b0; if_b.pixel_valid = 1'b0;

    // Directed frames.
    set_frame(8'd10, 8'd20, 8'd30, 8'd40, 0); frame_a(1'b0, 1'b0, 1'b0);
    set_frame(8'd1, 8'd1, 8'd1, 8'd2, 3);     frame_a(1'b0, 1'b0, 1'b0);
    set_frame(8'd255, 8'd255, 8'd255, 8'd255, 0); frame_a(1'b0, 1'b0, 1'b0);
    set_frame(8'd9, 8'd50, 8'd3, 8'd77, 2);   frame_a(1'b1, 1'b0, 1'b0);
    set_frame(8'd10, 8'd20, 8'd30, 8'd40, 0); frame_a(1'b0, 1'b0, 1'b0);

    // Asynchronous reset two pixels into a frame.
    @(negedge clk); if_a.start = 1'b1;
    @(negedge clk); if_a.start = 1'b0; if_a.pixel_valid = 1'b1; if_a.pixel_in = 8'd10;
    @(negedge clk); if_a.pixel_in = 8'd20;
    @(posedge clk); #2 rst = 1'b1;
    #1;
    chk("arst_a", 32'({if_a.ready, if_a.done, if_a.threshold}), 32'({2'b00, 8'd128}));
    if_a.pixel_valid = 1'b0;
    thr_a = 8'd128;
    @(negedge clk); @(negedge clk); rst = 1'b0;
    set_frame(8'd4, 8'd4, 8'd4, 8'd4, 0); frame_a(1'b0, 1'b0, 1'b0);

    // Random frames, some back-to-back via start in the done cycle.
    prev_chain = 1'b0;
    for (int f = 0; f < 12; f++) begin
      for (int i = 0; i < NPA; i++) begin
        fpx[i]  = (f % 4 == 3) ? 8'(255 - $urandom_range(0, 3)) : 8'($urandom);
        fgap[i] = int'($urandom_range(0, 3));
      end
      ch = (f != 11) && ($urandom_range(0, 1) == 1);
      frame_a(1'($urandom_range(0, 1)), prev_chain, ch);
      prev_chain = ch;
    end

    // Single-pixel frames.
    frame_b(8'd77);
    frame_b(8'd0);
    for (int f = 0; f < 4; f++) frame_b(8'($urandom));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
